// File: rtl/ahb_mtx_in_stg_pkg.sv
// Shared encodings for the AHB bus-matrix input stage.
package ahb_mtx_in_stg_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        ST_NO_DP = 2'd0,
        ST_HELD  = 2'd1,
        ST_DP    = 2'd2
    } dp_state_e;

endpackage

// File: rtl/ahb_mtx_in_stg_hold_reg.sv
// Holding register for one parked address phase, plus the live/held mux
// feeding the decoder.
module ahb_mtx_in_stg_hold_reg
    import ahb_mtx_in_stg_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned MST_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              live_sel,
    input  logic [ADDR_W-1:0] live_addr,
    input  logic [1:0]        live_trans,
    input  logic              live_write,
    input  logic [2:0]        live_size,
    input  logic [2:0]        live_burst,
    input  logic [3:0]        live_prot,
    input  logic [MST_W-1:0]  live_master,
    input  logic              live_mastlock,
    output logic              out_sel,
    output logic [ADDR_W-1:0] out_addr,
    output logic [1:0]        out_trans,
    output logic              out_write,
    output logic [2:0]        out_size,
    output logic [2:0]        out_burst,
    output logic [3:0]        out_prot,
    output logic [MST_W-1:0]  out_master,
    output logic              out_mastlock,
    output logic              held
);

    logic [ADDR_W-1:0] h_addr;
    logic [1:0]        h_trans;
    logic              h_write;
    logic [2:0]        h_size;
    logic [2:0]        h_burst;
    logic [3:0]        h_prot;
    logic [MST_W-1:0]  h_master;
    logic              h_mastlock;

    // Load wins over clear; the two never coincide because loading is
    // impossible while a transfer is already held.
    always_ff @(posedge clk) begin
        if (rst) begin
            held       <= 1'b0;
            h_addr     <= '0;
            h_trans    <= HTRANS_IDLE;
            h_write    <= 1'b0;
            h_size     <= '0;
            h_burst    <= '0;
            h_prot     <= '0;
            h_master   <= '0;
            h_mastlock <= 1'b0;
        end else if (load) begin
            held       <= 1'b1;
            h_addr     <= live_addr;
            h_trans    <= live_trans;
            h_write    <= live_write;
            h_size     <= live_size;
            h_burst    <= live_burst;
            h_prot     <= live_prot;
            h_master   <= live_master;
            h_mastlock <= live_mastlock;
        end else if (clear) begin
            held       <= 1'b0;
        end
    end

    always_comb begin
        out_sel      = live_sel;
        out_addr     = live_addr;
        out_trans    = live_trans;
        out_write    = live_write;
        out_size     = live_size;
        out_burst    = live_burst;
        out_prot     = live_prot;
        out_master   = live_master;
        out_mastlock = live_mastlock;
        if (held) begin
            out_sel      = 1'b1;
            out_addr     = h_addr;
            out_trans    = h_trans;
            out_write    = h_write;
            out_size     = h_size;
            out_burst    = h_burst;
            out_prot     = h_prot;
            out_master   = h_master;
            out_mastlock = h_mastlock;
        end
    end

endmodule

// File: rtl/ahb_mtx_in_stg.sv
// AHB bus-matrix input stage: parks ungranted address phases and tracks the
// master's data phase so the master sees the decoder's ready/response.
module ahb_mtx_in_stg
    import ahb_mtx_in_stg_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned MST_W  = 4
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [3:0]        HPROTS,
    input  logic [MST_W-1:0]  HMASTERS,
    input  logic              HMASTLOCKS,
    input  logic              HREADYS,
    input  logic              active_in,
    input  logic              readyout_in,
    input  logic [1:0]        resp_in,
    output logic              sel_in,
    output logic [ADDR_W-1:0] addr_in,
    output logic [1:0]        trans_in,
    output logic              write_in,
    output logic [2:0]        size_in,
    output logic [2:0]        burst_in,
    output logic [3:0]        prot_in,
    output logic [MST_W-1:0]  master_in,
    output logic              mastlock_in,
    output logic              held_tran_in,
    output logic              HREADYOUTS,
    output logic [1:0]        HRESPS
);

    dp_state_e state;
    dp_state_e next_state;
    logic      tran_valid;
    logic      hold_load;
    logic      hold_clear;

    assign tran_valid = HSELS & HTRANSS[1] & HREADYS;
    assign hold_load  = (state != ST_HELD) && (next_state == ST_HELD);
    assign hold_clear = (state == ST_HELD) && (next_state == ST_DP);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= ST_NO_DP;
        end else begin
            state <= next_state;
        end
    end

    // An accepted address phase either starts a data phase or gets parked.
    always_comb begin
        dp_state_e accept_state;
        accept_state = ST_NO_DP;
        if (tran_valid) begin
            accept_state = active_in ? ST_DP : ST_HELD;
        end
        next_state = state;
        case (state)
            ST_NO_DP: next_state = accept_state;
            ST_HELD:  if (active_in && readyout_in) next_state = ST_DP;
            ST_DP:    if (readyout_in) next_state = accept_state;
            default:  next_state = ST_NO_DP;
        endcase
    end

    always_comb begin
        HREADYOUTS = 1'b1;
        HRESPS     = HRESP_OKAY;
        case (state)
            ST_HELD: HREADYOUTS = 1'b0;
            ST_DP: begin
                HREADYOUTS = readyout_in;
                HRESPS     = resp_in;
            end
            default: ;
        endcase
    end

    ahb_mtx_in_stg_hold_reg #(
        .ADDR_W (ADDR_W),
        .MST_W  (MST_W)
    ) u_hold_reg (
        .clk           (HCLK),
        .rst           (HRESET),
        .load          (hold_load),
        .clear         (hold_clear),
        .live_sel      (HSELS),
        .live_addr     (HADDRS),
        .live_trans    (HTRANSS),
        .live_write    (HWRITES),
        .live_size     (HSIZES),
        .live_burst    (HBURSTS),
        .live_prot     (HPROTS),
        .live_master   (HMASTERS),
        .live_mastlock (HMASTLOCKS),
        .out_sel       (sel_in),
        .out_addr      (addr_in),
        .out_trans     (trans_in),
        .out_write     (write_in),
        .out_size      (size_in),
        .out_burst     (burst_in),
        .out_prot      (prot_in),
        .out_master    (master_in),
        .out_mastlock  (mastlock_in),
        .held          (held_tran_in)
    );

endmodule
